// File: rtl/data_memory_pkg.sv
// Shared types for the MEM-stage byte-enabled data memory.
// Access sizes, FSM states and lane-alignment bundles.
package data_memory_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } st_lane_t;

    typedef struct packed {
        logic [31:0] data;
        logic        misaligned;
    } ld_lane_t;

endpackage

// File: rtl/data_memory_be_if.sv
// Request/response handshake bundle between MEM stage and data memory.
// master = pipeline side, slave = memory side.
interface data_memory_be_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/replication and
// load extraction with sign/zero extension.
module mem_lane_align
    import data_memory_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  lane,
    input  logic        unsgn,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata,
    output logic        misaligned
);

    function automatic st_lane_t st_path(mem_size_e s, logic [1:0] a,
                                         logic [31:0] d);
        st_lane_t r;
        unique case (s)
            SIZE_BYTE: r = '{be: 4'b0001 << a, data: {4{d[7:0]}}};
            SIZE_HALF: r = '{be: a[1] ? 4'b1100 : 4'b0011,
                             data: {2{d[15:0]}}};
            SIZE_WORD: r = '{be: 4'b1111, data: d};
            default:   r = '{be: 4'b0000, data: d};
        endcase
        return r;
    endfunction

    function automatic ld_lane_t ld_path(logic [31:0] w, mem_size_e s,
                                         logic u, logic [1:0] a);
        ld_lane_t   r;
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        r.misaligned = (s == SIZE_HALF && a[0]) ||
                       (s == SIZE_WORD && a != 2'b00);
        unique case (s)
            SIZE_BYTE: r.data = {{24{~u & b[7]}}, b};
            SIZE_HALF: r.data = {{16{~u & h[15]}}, h};
            SIZE_WORD: r.data = w;
            default:   r.data = '0;
        endcase
        return r;
    endfunction

    st_lane_t st;
    ld_lane_t ld;

    assign st         = st_path(size, lane, wdata);
    assign ld         = ld_path(raw, size, unsgn, lane);
    assign be         = st.be;
    assign wdata_rep  = st.data;
    assign rdata      = ld.data;
    assign misaligned = ld.misaligned;

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed data memory with valid/ready handshake,
// programmable wait states and access error reporting.
module data_memory_be
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    data_memory_be_if.slave  bus
);

    localparam int          IW    = $clog2(DEPTH_WORDS);
    localparam int unsigned LIMIT = 4 * DEPTH_WORDS;
    localparam logic [3:0]  LAST  = 4'(WAIT_STATES - 1);

    mem_state_e state, state_nx;
    logic [3:0] cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic                  a_write, a_unsgn;
    mem_size_e             a_size;
    logic [ADDR_WIDTH-1:0] a_addr;

    logic                  c_write, c_unsgn, c_err;
    mem_size_e             c_size;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [IW-1:0]         widx;

    logic        accept, to_resp, misaligned;
    logic [3:0]  be;
    logic [31:0] wrep, raw, rext;

    // In IDLE the live request is the access; afterwards the latched one.
    always_comb begin
        c_write = a_write;
        c_unsgn = a_unsgn;
        c_size  = a_size;
        c_addr  = a_addr;
        if (state == IDLE) begin
            c_write = bus.req_write;
            c_unsgn = bus.req_unsigned;
            c_size  = mem_size_e'(bus.req_size);
            c_addr  = bus.req_addr;
        end
    end

    assign widx  = c_addr[IW+1:2];
    assign raw   = mem[widx];
    assign c_err = misaligned || c_size == SIZE_ILLEGAL ||
                   32'(c_addr) >= LIMIT;

    mem_lane_align u_align (
        .size       (c_size),
        .lane       (c_addr[1:0]),
        .unsgn      (c_unsgn),
        .wdata      (bus.req_wdata),
        .raw        (raw),
        .be         (be),
        .wdata_rep  (wrep),
        .rdata      (rext),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        accept        = 1'b0;
        to_resp       = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                accept        = bus.req_valid;
                if (accept) begin
                    state_nx = (WAIT_STATES > 0) ? WAIT : RESP;
                    to_resp  = (WAIT_STATES == 0);
                end
            end
            WAIT: begin
                if (cnt == LAST) begin
                    state_nx = RESP;
                    to_resp  = 1'b1;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            a_write       <= 1'b0;
            a_unsgn       <= 1'b0;
            a_size        <= SIZE_BYTE;
            a_addr        <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
        end else begin
            if (accept) begin
                a_write <= c_write;
                a_unsgn <= c_unsgn;
                a_size  <= c_size;
                a_addr  <= c_addr;
            end
            if (state == WAIT) cnt <= (cnt == LAST) ? '0 : cnt + 4'd1;
            if (to_resp) begin
                bus.rsp_error <= c_err;
                bus.rsp_rdata <= (c_err || c_write) ? '0 : rext;
            end
        end
    end

    // Array is deliberately not reset; stores commit at acceptance.
    always_ff @(posedge clk) begin
        if (accept && c_write && !c_err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_be.sv
// Randomized and directed bench for data_memory_be against a
// byte-array reference model; two instances (1 and 0 wait states).
module tb_data_memory_be;

    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_be_if #(.ADDR_WIDTH(AW)) ifa ();
    data_memory_be_if #(.ADDR_WIDTH(AW)) ifb ();

    data_memory_be #(
        .DEPTH_WORDS(256), .ADDR_WIDTH(AW), .WAIT_STATES(1)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

    data_memory_be #(
        .DEPTH_WORDS(256), .ADDR_WIDTH(AW), .WAIT_STATES(0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    assign ifb.req_write    = ifa.req_write;
    assign ifb.req_size     = ifa.req_size;
    assign ifb.req_unsigned = ifa.req_unsigned;
    assign ifb.req_addr     = ifa.req_addr;
    assign ifb.req_wdata    = ifa.req_wdata;

    logic        cur = 1'b0;
    logic        o_valid, o_ready, o_err;
    logic [31:0] o_rdata;
    assign o_valid = cur ? ifb.rsp_valid : ifa.rsp_valid;
    assign o_ready = cur ? ifb.req_ready : ifa.req_ready;
    assign o_err   = cur ? ifb.rsp_error : ifa.rsp_error;
    assign o_rdata = cur ? ifb.rsp_rdata : ifa.rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  ref_mem [2][1024];
    logic [31:0] got;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a flat byte array and the load/store rules in arithmetic.
    task automatic model(input bit sel, input bit wr, input logic [1:0] sz,
                         input bit u, input int addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int     n;
        longint v;
        n  = 1 << sz;
        er = (sz == 2'd3) || (addr % n != 0) || (addr >= 1024);
        rd = '0;
        if (er) return;
        if (wr) begin
            for (int k = 0; k < n; k++) ref_mem[sel][addr+k] = wd[8*k +: 8];
            return;
        end
        v = 0;
        for (int k = 0; k < n; k++)
            v += longint'(ref_mem[sel][addr+k]) << (8 * k);
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        rd = v[31:0];
    endtask

    task automatic xact(input bit sel, input bit wr, input logic [1:0] sz,
                        input bit u, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input int hold,
                        input bit poke, output logic [31:0] rd_obs);
        logic [31:0] erd, rd0;
        logic        eer, er0;
        int          lat;
        @(negedge clk);
        cur              = sel;
        ifa.req_write    = wr;
        ifa.req_size     = sz;
        ifa.req_unsigned = u;
        ifa.req_addr     = addr;
        ifa.req_wdata    = wd;
        if (sel) ifb.req_valid = 1'b1;
        else     ifa.req_valid = 1'b1;
        chk("req_ready_idle", 32'(o_ready), 32'd1);
        model(sel, wr, sz, u, int'(addr), wd, erd, eer);
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, sel ? 32'd1 : 32'd2);
        rd_obs = o_rdata;
        chk("rdata", o_rdata, erd);
        chk("error", 32'(o_err), 32'(eer));
        rd0 = o_rdata;
        er0 = o_err;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                ifa.req_write = 1'b1;
                ifa.req_size  = 2'd2;
                ifa.req_addr  = 11'h030;
                ifa.req_wdata = 32'hCAFEF00D;
                if (sel) ifb.req_valid = 1'b1;
                else     ifa.req_valid = 1'b1;
            end
            @(negedge clk);
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_rdata", o_rdata, rd0);
            chk("hold_error", 32'(o_err), 32'(er0));
            chk("hold_ready", 32'(o_ready), 32'd0);
        end
        if (sel) ifb.rsp_ready = 1'b1;
        else     ifa.rsp_ready = 1'b1;
        @(negedge clk);
        ifa.rsp_ready = 1'b0;
        ifb.rsp_ready = 1'b0;
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
        chk("post_valid", 32'(o_valid), 32'd0);
        chk("post_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [31:0]   erd;
        logic          eer;
        logic [1:0]    sz;
        logic [AW-1:0] ad;
        ifa.req_valid = 1'b0; ifb.req_valid = 1'b0;
        ifa.rsp_ready = 1'b0; ifb.rsp_ready = 1'b0;
        ifa.req_write = 1'b0; ifa.req_size = 2'd0;
        ifa.req_unsigned = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_a", 32'(ifa.req_ready), 32'd1);
        chk("rst_valid_a", 32'(ifa.rsp_valid), 32'd0);
        chk("rst_rdata_a", ifa.rsp_rdata, 32'd0);
        chk("rst_error_a", 32'(ifa.rsp_error), 32'd0);
        chk("rst_ready_b", 32'(ifb.req_ready), 32'd1);
        chk("rst_valid_b", 32'(ifb.rsp_valid), 32'd0);

        for (int w = 0; w < 256; w++)
            xact(0, 1, 2'd2, 0, 11'(4 * w), $urandom, 0, 0, got);
        for (int w = 0; w < 16; w++)
            xact(1, 1, 2'd2, 0, 11'(4 * w), $urandom, 0, 0, got);

        xact(0, 1, 2'd2, 0, 11'h010, 32'hDEADBEEF, 0, 0, got);
        xact(0, 0, 2'd2, 0, 11'h010, 32'h0, 0, 0, got);
        chk("lw_word", got, 32'hDEADBEEF);
        xact(0, 1, 2'd0, 0, 11'h012, 32'hAAAAAA7F, 0, 0, got);
        xact(0, 0, 2'd2, 1, 11'h010, 32'h0, 0, 0, got);
        chk("lw_after_sb", got, 32'hDE7FBEEF);
        xact(0, 0, 2'd0, 0, 11'h013, 32'h0, 0, 0, got);
        chk("lb_sign", got, 32'hFFFFFFDE);
        xact(0, 0, 2'd0, 1, 11'h013, 32'h0, 0, 0, got);
        chk("lbu_zero", got, 32'h000000DE);
        xact(0, 1, 2'd2, 0, 11'h020, 32'h0, 0, 0, got);
        xact(0, 1, 2'd1, 0, 11'h020, 32'h55558001, 0, 0, got);
        xact(0, 0, 2'd1, 0, 11'h020, 32'h0, 0, 0, got);
        chk("lh_sign", got, 32'hFFFF8001);
        xact(0, 0, 2'd1, 1, 11'h020, 32'h0, 0, 0, got);
        chk("lhu_zero", got, 32'h00008001);
        xact(0, 0, 2'd2, 0, 11'h011, 32'h0, 0, 0, got);
        chk("lw_mis_rdata", got, 32'h0);
        xact(0, 1, 2'd1, 0, 11'h021, 32'h00001234, 0, 0, got);
        xact(0, 0, 2'd2, 0, 11'h020, 32'h0, 0, 0, got);
        chk("sh_mis_kept", got, 32'h00008001);
        xact(0, 0, 2'd3, 0, 11'h020, 32'h0, 0, 0, got);
        xact(0, 0, 2'd2, 0, 11'h400, 32'h0, 0, 0, got);

        // Backpressure with a competing request held on the bus.
        xact(0, 0, 2'd2, 0, 11'h010, 32'h0, 5, 1, got);
        chk("bp_rdata", got, 32'hDE7FBEEF);
        xact(0, 0, 2'd2, 0, 11'h030, 32'h0, 0, 0, got);
        xact(0, 1, 2'd2, 0, 11'h030, 32'hCAFEF00D, 0, 0, got);
        xact(0, 0, 2'd2, 0, 11'h030, 32'h0, 0, 0, got);
        chk("bp_second", got, 32'hCAFEF00D);

        // Reset while a store sits in WAIT.
        @(negedge clk);
        cur = 1'b0;
        ifa.req_write = 1'b1; ifa.req_size = 2'd2;
        ifa.req_addr = 11'h040; ifa.req_wdata = 32'h0BADF00D;
        ifa.req_valid = 1'b1;
        model(0, 1, 2'd2, 0, 32'h40, 32'h0BADF00D, erd, eer);
        @(posedge clk);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        chk("wait_ready", 32'(ifa.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid_a", 32'(ifa.rsp_valid), 32'd0);
        chk("rst_mid_ready_a", 32'(ifa.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        xact(0, 0, 2'd2, 0, 11'h040, 32'h0, 0, 0, got);
        chk("rst_store_kept", got, 32'h0BADF00D);

        // Reset while the zero-wait instance holds a response.
        @(negedge clk);
        cur = 1'b1;
        ifa.req_write = 1'b0; ifa.req_size = 2'd2; ifa.req_addr = 11'h004;
        ifb.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.req_valid = 1'b0;
        chk("b_resp_valid", 32'(ifb.rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid_b", 32'(ifb.rsp_valid), 32'd0);
        chk("rst_mid_ready_b", 32'(ifb.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (300) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 19) == 0) ? 11'($urandom_range(1024, 2047))
                                               : 11'($urandom_range(0, 1023));
            xact(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 ad, $urandom, $urandom_range(0, 2), 0, got);
        end
        repeat (60) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1024, 2047))
                                              : 11'($urandom_range(0, 63));
            xact(1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                 ad, $urandom, $urandom_range(0, 2), 0, got);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
